io_stream_bridge: RTL

Parametrised width-converting stream bridge between the user-project GPIO pads and the core AXI4-Stream ports of the spectrometer. It replaces direct pad-to-port wiring: narrow pad beats are gathered into core-width words through a buffered input path, and core-width words are split into narrow pad beats through a skid-free output path. Beat order, per-beat bit reversal, early-`last` handling, an enable gate and wrapping word counters are added so pad counts can shrink without changing the core.

---
 rtl/io_stream_pkg.sv | 48 ++++
 rtl/io_stream_bridge_fifo.sv | 70 +++++++
 rtl/io_stream_bridge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/io_stream_pkg.sv
// Shared helpers for the pad/core stream bridge: ratio derivation, ceil-log2 and
// bit reversal used when placing pad beats into core words.
package io_stream_pkg;

    localparam int MAX_W = 64;

    typedef logic [31:0] word_cnt_t;

    // Returns wide/narrow, or 0 when the ratio is not a positive integer.
    function automatic int ratio(input int wide, input int narrow);
        if (narrow <= 0) begin
            return 0;
        end else if ((wide % narrow) != 0) begin
            return 0;
        end else begin
            return wide / narrow;
        end
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits when the ratio is 1.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Reverses the low w bits of x; the result sits in the low w bits.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[i] = x[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/io_stream_bridge_fifo.sv
// Synchronous word FIFO for the input path; head output reads as zero when empty
// so that stale storage never shows on the core port.
module stream_fifo
    import io_stream_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push_s, do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push_s) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/io_stream_bridge.sv
// Width-converting bridge: gathers narrow pad beats into core words through a FIFO
// and splits core words into narrow pad beats through a single hold register.
module io_stream_bridge
    import io_stream_pkg::*;
#(
    parameter int PAD_IN_W       = 8,
    parameter int CORE_IN_W      = 8,
    parameter int PAD_OUT_W      = 16,
    parameter int CORE_OUT_W     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int BIT_REVERSE_IN = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  en,
    input  logic                  pad_in_valid,
    input  logic                  pad_in_last,
    input  logic [PAD_IN_W-1:0]   pad_in_data,
    output logic                  pad_in_ready,
    output logic                  core_in_valid,
    input  logic                  core_in_ready,
    output logic [CORE_IN_W-1:0]  core_in_data,
    output logic                  core_in_last,
    input  logic                  core_out_valid,
    output logic                  core_out_ready,
    input  logic [CORE_OUT_W-1:0] core_out_data,
    input  logic                  core_out_last,
    output logic                  pad_out_valid,
    input  logic                  pad_out_ready,
    output logic [PAD_OUT_W-1:0]  pad_out_data,
    output logic                  pad_out_last,
    output logic [31:0]           in_word_cnt,
    output logic [31:0]           out_word_cnt
);

    localparam int R_IN  = ratio(CORE_IN_W, PAD_IN_W);
    localparam int R_OUT = ratio(CORE_OUT_W, PAD_OUT_W);
    localparam int IB_W  = cnt_w(R_IN);
    localparam int OB_W  = cnt_w(R_OUT);
    localparam int FW    = CORE_IN_W + 1;

    if (R_IN < 1 || PAD_IN_W > MAX_W) begin : g_bad_in_ratio
        $error("io_stream_bridge: CORE_IN_W must be an integer multiple of PAD_IN_W");
    end
    if (R_OUT < 1) begin : g_bad_out_ratio
        $error("io_stream_bridge: CORE_OUT_W must be an integer multiple of PAD_OUT_W");
    end

    logic [PAD_IN_W-1:0]   beat_s;
    logic                  in_fire_s, word_done_s;
    logic [CORE_IN_W-1:0]  asm_q, asm_d, word_s;
    logic [IB_W-1:0]       ib_q, ib_d;
    logic                  fifo_full_s, fifo_empty_s;
    logic [FW-1:0]         fifo_head_s;
    word_cnt_t             in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [CORE_OUT_W-1:0] hold_q, hold_d;
    logic                  hv_q, hv_d, hl_q, hl_d;
    logic [OB_W-1:0]       ob_q, ob_d;
    logic                  final_beat_s, core_acc_s, pad_fire_s;

    // ---------------- input path ----------------
    assign beat_s = (BIT_REVERSE_IN != 0)
                  ? PAD_IN_W'(bitrev(MAX_W'(pad_in_data), PAD_IN_W))
                  : pad_in_data;

    assign pad_in_ready = en && !fifo_full_s;
    assign in_fire_s    = pad_in_valid && pad_in_ready;
    assign word_done_s  = in_fire_s && ((ib_q == IB_W'(R_IN - 1)) || pad_in_last);

    // Assembly next-state; a completed word is cleared so early-last words stay zero-padded.
    always_comb begin
        asm_d    = asm_q;
        ib_d     = ib_q;
        in_cnt_d = in_cnt_q;
        word_s   = asm_q;
        word_s[ib_q*PAD_IN_W +: PAD_IN_W] = beat_s;
        if (word_done_s) begin
            asm_d    = '0;
            ib_d     = '0;
            in_cnt_d = in_cnt_q + 32'd1;
        end else if (in_fire_s) begin
            asm_d = word_s;
            ib_d  = ib_q + IB_W'(1);
        end else begin
            asm_d = asm_q;
            ib_d  = ib_q;
        end
    end

    stream_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .push_i      (word_done_s),
        .push_data_i ({pad_in_last, word_s}),
        .pop_i       (core_in_ready),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign core_in_valid = !fifo_empty_s;
    assign core_in_data  = fifo_head_s[CORE_IN_W-1:0];
    assign core_in_last  = fifo_head_s[CORE_IN_W];

    // ---------------- output path ----------------
    assign final_beat_s   = (ob_q == OB_W'(R_OUT - 1));
    assign core_out_ready = en && (!hv_q || (pad_out_ready && final_beat_s));
    assign core_acc_s     = core_out_valid && core_out_ready;
    assign pad_fire_s     = hv_q && pad_out_ready;

    assign pad_out_valid = hv_q;
    assign pad_out_data  = hold_q[ob_q*PAD_OUT_W +: PAD_OUT_W];
    assign pad_out_last  = hl_q && final_beat_s;

    // Hold-register next-state; a reload on the final beat gives back-to-back words.
    always_comb begin
        hold_d    = hold_q;
        hv_d      = hv_q;
        hl_d      = hl_q;
        ob_d      = ob_q;
        out_cnt_d = out_cnt_q;
        if (pad_fire_s && final_beat_s) begin
            out_cnt_d = out_cnt_q + 32'd1;
        end else begin
            out_cnt_d = out_cnt_q;
        end
        if (core_acc_s) begin
            hold_d = core_out_data;
            hv_d   = 1'b1;
            hl_d   = core_out_last;
            ob_d   = '0;
        end else if (pad_fire_s && final_beat_s) begin
            hv_d = 1'b0;
            hl_d = 1'b0;
            ob_d = '0;
        end else if (pad_fire_s) begin
            ob_d = ob_q + OB_W'(1);
        end else begin
            ob_d = ob_q;
        end
    end

    // State registers for both paths and the word counters.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            asm_q     <= '0;
            ib_q      <= '0;
            in_cnt_q  <= '0;
            hold_q    <= '0;
            hv_q      <= 1'b0;
            hl_q      <= 1'b0;
            ob_q      <= '0;
            out_cnt_q <= '0;
        end else begin
            asm_q     <= asm_d;
            ib_q      <= ib_d;
            in_cnt_q  <= in_cnt_d;
            hold_q    <= hold_d;
            hv_q      <= hv_d;
            hl_q      <= hl_d;
            ob_q      <= ob_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign in_word_cnt  = in_cnt_q;
    assign out_word_cnt = out_cnt_q;

endmodule
